// File: rtl/rv_pkg.sv
// ============================================================================
// Module  : rv_pkg
// Brief   : Shared types and constants for the register-file write arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } rfa_state_t;

endpackage

`default_nettype wire

// File: rtl/rf_write_arbiter_if.sv
// ============================================================================
// Module  : rf_write_arbiter_if
// Brief   : Requester handshakes plus regfile write-port bundle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface rf_write_arbiter_if #(
    parameter int BITS = 32
);
    import rv_pkg::*;

    logic                  init_req;
    logic                  init_done;

    logic                  req0_valid;
    logic                  req0_ready;
    logic [REG_ADDR_W-1:0] req0_addr;
    logic [BITS-1:0]       req0_data;

    logic                  req1_valid;
    logic                  req1_ready;
    logic [REG_ADDR_W-1:0] req1_addr;
    logic [BITS-1:0]       req1_data;

    logic [REG_ADDR_W-1:0] rf_address_write;
    logic                  rf_write_enable;
    logic [BITS-1:0]       rf_data_write;

    // Arbiter side.
    modport slave (
        input  init_req,
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready,
        output rf_address_write, rf_write_enable, rf_data_write,
        output init_done
    );

    // Pipeline / regfile side.
    modport master (
        output init_req,
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready,
        input  rf_address_write, rf_write_enable, rf_data_write,
        input  init_done
    );

endinterface

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// Module  : rr_arb2
// Brief   : Two-way round-robin arbiter; the loser of a grant gets priority.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2 (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       i_enable,
    input  wire logic [1:0] i_valid,
    output logic      [1:0] o_grant
);

    logic       r_prio;
    logic [1:0] w_grant;

    always_comb begin
        w_grant = 2'b00;
        if (i_enable) begin
            case (i_valid)
                2'b01:   w_grant = 2'b01;
                2'b10:   w_grant = 2'b10;
                2'b11:   w_grant = r_prio ? 2'b10 : 2'b01;
                default: w_grant = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio <= 1'b0;
        end else if (w_grant[0]) begin
            r_prio <= 1'b1;
        end else if (w_grant[1]) begin
            r_prio <= 1'b0;
        end
    end

    assign o_grant = w_grant;

endmodule

`default_nettype wire

// File: rtl/rf_write_arbiter.sv
// ============================================================================
// Module  : rf_write_arbiter
// Brief   : Owns the regfile write port: zero-fills x1..x(REGS-1), then
//           round-robin arbitrates two writeback requesters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_write_arbiter
    import rv_pkg::*;
#(
    parameter int BITS = 32,
    parameter int REGS = 32
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    rf_write_arbiter_if.slave bus
);

    localparam logic [REG_ADDR_W-1:0] c_LAST  = REG_ADDR_W'(REGS - 1);
    localparam logic [REG_ADDR_W-1:0] c_FIRST = 5'd1;

    rfa_state_t            r_state;
    logic [REG_ADDR_W-1:0] r_cnt;
    logic [REG_ADDR_W-1:0] r_addr;
    logic [BITS-1:0]       r_data;
    logic                  r_we;

    logic                  w_enable;
    logic [1:0]            w_grant;
    logic [REG_ADDR_W-1:0] w_sel_addr;
    logic [BITS-1:0]       w_sel_data;

    // init_req blocks any grant in the cycle it is seen.
    assign w_enable = (r_state == RUN) && !bus.init_req;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_enable (w_enable),
        .i_valid  ({bus.req1_valid, bus.req0_valid}),
        .o_grant  (w_grant)
    );

    assign w_sel_addr = w_grant[1] ? bus.req1_addr : bus.req0_addr;
    assign w_sel_data = w_grant[1] ? bus.req1_data : bus.req0_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= INIT;
            r_cnt   <= c_FIRST;
            r_addr  <= '0;
            r_data  <= '0;
            r_we    <= 1'b0;
        end else begin
            case (r_state)
                INIT: begin
                    r_addr <= r_cnt;
                    r_data <= '0;
                    r_we   <= 1'b1;
                    r_cnt  <= r_cnt + 5'd1;
                    if (r_cnt == c_LAST) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (bus.init_req) begin
                        r_we    <= 1'b0;
                        r_cnt   <= c_FIRST;
                        r_state <= INIT;
                    end else if (|w_grant) begin
                        r_addr <= w_sel_addr;
                        r_data <= w_sel_data;
                        // x0 writes are handshaken but never reach the regfile.
                        r_we   <= (w_sel_addr != REG_ZERO);
                    end else begin
                        r_we <= 1'b0;
                    end
                end
                default: begin
                    r_state <= INIT;
                    r_cnt   <= c_FIRST;
                    r_we    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req0_ready       = w_grant[0];
    assign bus.req1_ready       = w_grant[1];
    assign bus.rf_address_write = r_addr;
    assign bus.rf_data_write    = r_data;
    assign bus.rf_write_enable  = r_we;
    assign bus.init_done        = (r_state == RUN);

endmodule

`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
// ============================================================================
// Module  : tb_rf_write_arbiter
// Brief   : Scoreboard bench: expected regfile writes are queued by the
//           stimulus and popped by a monitor whenever a write is presented.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rf_write_arbiter;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic clk;
    logic rst_n;

    rf_write_arbiter_if #(.BITS(32)) bus ();

    rf_write_arbiter #(.BITS(32), .REGS(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int total;
    int bad;
    wr_t exp_q[$];
    logic [31:0] mem [32];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Regfile model: commits presented writes on the rising edge.
    initial for (int i = 0; i < 32; i++) mem[i] = 32'hdeadbeef;
    always @(posedge clk) begin
        if (bus.rf_write_enable && bus.rf_address_write != 5'd0)
            mem[bus.rf_address_write] <= bus.rf_data_write;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every presented write must match the head of the queue.
    always @(negedge clk) begin
        if (rst_n && bus.rf_write_enable === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write_addr", {27'd0, bus.rf_address_write}, 32'hffffffff);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", {27'd0, bus.rf_address_write}, {27'd0, e.addr});
                check("wr_data", bus.rf_data_write, e.data);
            end
        end
    end

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in INIT with cnt = 1, before the first fill edge.
    task automatic run_fill();
        for (int a = 1; a < 32; a++) push(5'(a), 32'd0);
        for (int i = 1; i <= 31; i++) begin
            step();
            if (i == 1)  check("fill_first_addr", {27'd0, bus.rf_address_write}, 32'd1);
            if (i == 30) check("fill_init_done_low", {31'd0, bus.init_done}, 32'd0);
            if (i < 31)  check("fill_ready0_low", {31'd0, bus.req0_ready}, 32'd0);
            if (i == 31) check("fill_init_done_high", {31'd0, bus.init_done}, 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.init_req   = 1'b0;
        bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
        bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;

        // Reset state
        step();
        step();
        check("rst_we",        {31'd0, bus.rf_write_enable}, 32'd0);
        check("rst_addr",      {27'd0, bus.rf_address_write}, 32'd0);
        check("rst_data",      bus.rf_data_write, 32'd0);
        check("rst_init_done", {31'd0, bus.init_done}, 32'd0);

        // Reset fill with a request waiting from the start
        rst_n = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd1; bus.req0_data = 32'haabbccdd;
        run_fill();
        check("single_ready0_first_run_cycle", {31'd0, bus.req0_ready}, 32'd1);
        push(5'd1, 32'haabbccdd);
        step();
        bus.req0_valid = 1'b0;
        check("single_addr", {27'd0, bus.rf_address_write}, 32'd1);
        check("single_data", bus.rf_data_write, 32'haabbccdd);
        check("single_we",   {31'd0, bus.rf_write_enable}, 32'd1);
        step();
        check("single_regfile_x1", mem[1], 32'haabbccdd);

        // x0 write: accepted, suppressed; also hands priority back to req0
        bus.req1_valid = 1'b1; bus.req1_addr = 5'd0; bus.req1_data = 32'ha0a0a0a0;
        #1;
        check("x0_ready1", {31'd0, bus.req1_ready}, 32'd1);
        check("x0_ready0", {31'd0, bus.req0_ready}, 32'd0);
        step();
        bus.req1_valid = 1'b0;
        check("x0_we",   {31'd0, bus.rf_write_enable}, 32'd0);
        check("x0_addr", {27'd0, bus.rf_address_write}, 32'd0);
        check("x0_data", bus.rf_data_write, 32'ha0a0a0a0);

        // Contention: grants alternate 0,1,0,1
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd2; bus.req0_data = 32'hffffffff;
        bus.req1_valid = 1'b1; bus.req1_addr = 5'd3; bus.req1_data = 32'h12345678;
        push(5'd2, 32'hffffffff); push(5'd3, 32'h12345678);
        push(5'd2, 32'hffffffff); push(5'd3, 32'h12345678);
        for (int c = 0; c < 4; c++) begin
            #1;
            check("cont_ready0", {31'd0, bus.req0_ready}, (c % 2 == 0) ? 32'd1 : 32'd0);
            check("cont_ready1", {31'd0, bus.req1_ready}, (c % 2 == 1) ? 32'd1 : 32'd0);
            step();
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        step();
        check("cont_regfile_x2", mem[2], 32'hffffffff);
        check("cont_regfile_x3", mem[3], 32'h12345678);

        // Mid-operation reset during a stream to x5
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd5; bus.req0_data = 32'h55555555;
        push(5'd5, 32'h55555555); push(5'd5, 32'h55555555);
        step();
        step();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_we",        {31'd0, bus.rf_write_enable}, 32'd0);
        check("midrst_addr",      {27'd0, bus.rf_address_write}, 32'd0);
        check("midrst_data",      bus.rf_data_write, 32'd0);
        check("midrst_init_done", {31'd0, bus.init_done}, 32'd0);
        check("midrst_x5_first_write", mem[5], 32'h55555555);
        bus.req0_valid = 1'b0;
        step();
        rst_n = 1'b1;
        run_fill();
        step();
        check("midrst_regfile_x5", mem[5], 32'd0);
        check("midrst_regfile_x31", mem[31], 32'd0);

        // Re-init with a pending request
        bus.init_req = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd6; bus.req0_data = 32'h66666666;
        #1;
        check("reinit_ready0_blocked", {31'd0, bus.req0_ready}, 32'd0);
        check("reinit_init_done_still", {31'd0, bus.init_done}, 32'd1);
        step();
        bus.init_req = 1'b0;
        check("reinit_init_done_fall", {31'd0, bus.init_done}, 32'd0);
        check("reinit_we_idle", {31'd0, bus.rf_write_enable}, 32'd0);
        run_fill();
        check("reinit_ready0_after_fill", {31'd0, bus.req0_ready}, 32'd1);
        push(5'd6, 32'h66666666);
        step();
        bus.req0_valid = 1'b0;
        check("reinit_addr", {27'd0, bus.rf_address_write}, 32'd6);
        check("reinit_we",   {31'd0, bus.rf_write_enable}, 32'd1);
        repeat (3) step();
        check("reinit_regfile_x6", mem[6], 32'h66666666);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
